m_imem_loader: RTL



---
 rtl/m_imem_loader_pkg.sv | 45 ++++
 rtl/m_uart_rx.sv | 132 +++++++++++++
 rtl/m_imem_loader.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/m_imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// m_imem_loader_pkg
//   Shared definitions for the serial instruction-memory loader:
//   - C_SYNC_BYTE : default frame start marker
//   - LEN_W       : width of the frame word-count field
//   - ADDR_W      : instruction-memory word address width
//   - t_ld_state  : loader FSM state encoding
//   - t_rx_state  : UART receiver state encoding
//   - f_is_busy   : states in which a frame is in progress
//   Optional feature macro: LOADER_CHECKSUM_EN (adds the CSUM state).
// -----------------------------------------------------------------------------
package m_imem_loader_pkg;

   localparam logic [7:0] C_SYNC_BYTE = 8'hA5;
   localparam int         LEN_W       = 16;
   localparam int         ADDR_W      = 12;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LEN_H = 3'd1,
      S_LEN_L = 3'd2,
      S_DATA  = 3'd3,
`ifdef LOADER_CHECKSUM_EN
      S_CSUM  = 3'd4,
`endif
      S_DONE  = 3'd5,
      S_ERR   = 3'd6
   } t_ld_state;

   typedef enum logic [1:0] {
      U_IDLE  = 2'd0,
      U_START = 2'd1,
      U_DATA  = 2'd2,
      U_STOP  = 2'd3
   } t_rx_state;

   function automatic logic f_is_busy(input t_ld_state s);
`ifdef LOADER_CHECKSUM_EN
      return (s == S_LEN_H) || (s == S_LEN_L) || (s == S_DATA) || (s == S_CSUM);
`else
      return (s == S_LEN_H) || (s == S_LEN_L) || (s == S_DATA);
`endif
   endfunction

endpackage

// File: rtl/m_uart_rx.sv
// -----------------------------------------------------------------------------
// m_uart_rx
//   8N1 UART receiver. The serial input is synchronised through two flops,
//   a falling edge starts a byte, the start bit is re-checked half a bit later,
//   data bits are sampled LSB first at mid-bit and the stop bit is sampled at
//   mid-bit. A good stop bit yields a 1-cycle r_valid strobe with r_data; a
//   low stop bit yields a 1-cycle r_ferr pulse instead.
//
//   Parameters:
//     CLKS_PER_BIT : clock cycles per UART bit (>= 4)
//   Ports:
//     w_clk   in   system clock
//     w_rst   in   synchronous active-high reset
//     w_rxd   in   serial input, idle high, asynchronous to w_clk
//     r_valid out  1-cycle byte strobe
//     r_data  out  received byte, valid with r_valid
//     r_ferr  out  1-cycle framing-error pulse
// -----------------------------------------------------------------------------
module m_uart_rx
   import m_imem_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       w_clk,
   input  logic       w_rst,
   input  logic       w_rxd,
   output logic       r_valid,
   output logic [7:0] r_data,
   output logic       r_ferr
);

   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] C_FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2 - 1);

   logic            r_rxd_s1;
   logic            r_rxd_s2;
   logic            r_rxd_s3;   // previous synchronised level, for edge detect
   t_rx_state       r_state;
   logic [CW-1:0]   r_cnt;
   logic [2:0]      r_bit;
   logic [7:0]      r_shift;

   t_rx_state       w_state_nxt;
   logic [CW-1:0]   w_cnt_nxt;
   logic [2:0]      w_bit_nxt;
   logic [7:0]      w_shift_nxt;
   logic            w_valid_nxt;
   logic [7:0]      w_data_nxt;
   logic            w_ferr_nxt;

   always_ff @(posedge w_clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples pre-edge values regardless of statement order.
      if (w_rst) begin
         // NOTE: the synchroniser resets to the idle-high line level so that
         // leaving reset is never mistaken for a start-bit falling edge.
         r_rxd_s1 <= 1'b1;
         r_rxd_s2 <= 1'b1;
         r_rxd_s3 <= 1'b1;
         r_state  <= U_IDLE;
         r_cnt    <= '0;
         r_bit    <= '0;
         r_shift  <= '0;
         r_valid  <= 1'b0;
         r_data   <= '0;
         r_ferr   <= 1'b0;
      end else begin
         r_rxd_s1 <= w_rxd;
         r_rxd_s2 <= r_rxd_s1;
         r_rxd_s3 <= r_rxd_s2;
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_bit    <= w_bit_nxt;
         r_shift  <= w_shift_nxt;
         r_valid  <= w_valid_nxt;
         r_data   <= w_data_nxt;
         r_ferr   <= w_ferr_nxt;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case can leave a value unassigned and infer a latch.
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + 1'b1;
      w_bit_nxt   = r_bit;
      w_shift_nxt = r_shift;
      w_valid_nxt = 1'b0;
      w_data_nxt  = r_data;
      w_ferr_nxt  = 1'b0;

      case (r_state)
         U_IDLE: begin
            w_cnt_nxt = '0;
            if (r_rxd_s3 && !r_rxd_s2)
               w_state_nxt = U_START;
         end
         U_START: begin
            if (r_cnt == C_HALF) begin
               w_cnt_nxt   = '0;
               w_bit_nxt   = '0;
               // A start bit that is high again at mid-bit was a glitch.
               w_state_nxt = r_rxd_s2 ? U_IDLE : U_DATA;
            end
         end
         U_DATA: begin
            if (r_cnt == C_FULL) begin
               w_cnt_nxt   = '0;
               w_shift_nxt = {r_rxd_s2, r_shift[7:1]};
               w_bit_nxt   = r_bit + 1'b1;
               if (r_bit == 3'd7)
                  w_state_nxt = U_STOP;
            end
         end
         U_STOP: begin
            if (r_cnt == C_FULL) begin
               w_cnt_nxt   = '0;
               w_state_nxt = U_IDLE;
               if (r_rxd_s2) begin
                  w_valid_nxt = 1'b1;
                  w_data_nxt  = r_shift;
               end else begin
                  w_ferr_nxt  = 1'b1;
               end
            end
         end
         default: w_state_nxt = U_IDLE;
      endcase
   end

endmodule

// File: rtl/m_imem_loader.sv
// -----------------------------------------------------------------------------
// m_imem_loader
//   Serial program loader in front of the instruction memory. Receives a frame
//   SYNC, N[15:8], N[7:0], 4N payload bytes (big-endian words) and, when
//   LOADER_CHECKSUM_EN is defined, one trailing byte equal to the 8-bit sum of
//   the payload. Each assembled word is written through the memory write port.
//   The processor is held in reset until a complete, valid image is written.
//
//   Optional feature macro: LOADER_CHECKSUM_EN
//
//   Parameters:
//     CLKS_PER_BIT : clock cycles per UART bit
//     SYNC_BYTE    : frame start marker
//     MAX_WORDS    : instruction memory depth in words
//   Ports:
//     w_clk        in   system clock
//     w_rst        in   synchronous active-high reset
//     w_rxd        in   UART serial input, idle high
//     r_imem_we    out  instruction-memory write strobe (single cycle)
//     r_imem_addr  out  word address for the write port
//     r_imem_din   out  assembled 32-bit word
//     r_proc_rst   out  processor reset request (low once the image is loaded)
//     r_busy       out  frame in progress
//     r_err        out  last frame rejected
// -----------------------------------------------------------------------------
module m_imem_loader
   import m_imem_loader_pkg::*;
#(
   parameter int         CLKS_PER_BIT = 434,
   parameter logic [7:0] SYNC_BYTE    = C_SYNC_BYTE,
   parameter int         MAX_WORDS    = 4096
) (
   input  logic              w_clk,
   input  logic              w_rst,
   input  logic              w_rxd,
   output logic              r_imem_we,
   output logic [ADDR_W-1:0] r_imem_addr,
   output logic [31:0]       r_imem_din,
   output logic              r_proc_rst,
   output logic              r_busy,
   output logic              r_err
);

   localparam logic [LEN_W-1:0] C_MAX_N = LEN_W'(MAX_WORDS);

   // UART byte interface
   logic             w_rx_valid;
   logic [7:0]       w_rx_data;
   logic             w_rx_ferr;

   // Loader state
   t_ld_state        r_state;
   logic [7:0]       r_len_h;
   logic [LEN_W-1:0] r_len;
   logic [LEN_W-1:0] r_word_cnt;
   logic [1:0]       r_byte_cnt;

   t_ld_state        w_state_nxt;
   logic [7:0]       w_len_h_nxt;
   logic [LEN_W-1:0] w_len_nxt;
   logic [LEN_W-1:0] w_word_nxt;
   logic [1:0]       w_byte_nxt;
   logic [ADDR_W-1:0] w_addr_nxt;
   logic [31:0]      w_din_nxt;
   logic             w_we_nxt;
   logic [LEN_W-1:0] w_len_rx;

`ifdef LOADER_CHECKSUM_EN
   logic [7:0]       r_sum;
   logic [7:0]       w_sum_nxt;
`endif

   m_uart_rx #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_uart_rx (
      .w_clk   (w_clk),
      .w_rst   (w_rst),
      .w_rxd   (w_rxd),
      .r_valid (w_rx_valid),
      .r_data  (w_rx_data),
      .r_ferr  (w_rx_ferr)
   );

   // Full word count as seen while the low length byte is on the bus.
   assign w_len_rx = {r_len_h, w_rx_data};

   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         r_state     <= S_IDLE;
         r_len_h     <= '0;
         r_len       <= '0;
         r_word_cnt  <= '0;
         r_byte_cnt  <= '0;
         r_imem_we   <= 1'b0;
         r_imem_addr <= '0;
         r_imem_din  <= '0;
         r_proc_rst  <= 1'b1;
         r_busy      <= 1'b0;
         r_err       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         r_sum       <= '0;
`endif
      end else begin
         r_state     <= w_state_nxt;
         r_len_h     <= w_len_h_nxt;
         r_len       <= w_len_nxt;
         r_word_cnt  <= w_word_nxt;
         r_byte_cnt  <= w_byte_nxt;
         r_imem_we   <= w_we_nxt;
         r_imem_addr <= w_addr_nxt;
         r_imem_din  <= w_din_nxt;
         // Released one cycle after DONE is reached, so the final write
         // has already committed when the processor starts fetching.
         r_proc_rst  <= (r_state != S_DONE);
         r_busy      <= f_is_busy(w_state_nxt);
         r_err       <= (w_state_nxt == S_ERR);
`ifdef LOADER_CHECKSUM_EN
         r_sum       <= w_sum_nxt;
`endif
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_len_h_nxt = r_len_h;
      w_len_nxt   = r_len;
      w_word_nxt  = r_word_cnt;
      w_byte_nxt  = r_byte_cnt;
      w_din_nxt   = r_imem_din;
      w_we_nxt    = 1'b0;
      // Address is held through the write cycle and advances right after it.
      w_addr_nxt  = r_imem_we ? r_imem_addr + 1'b1 : r_imem_addr;
`ifdef LOADER_CHECKSUM_EN
      w_sum_nxt   = r_sum;
`endif

      case (r_state)
         S_IDLE: begin
            if (w_rx_valid && (w_rx_data == SYNC_BYTE))
               w_state_nxt = S_LEN_H;
         end
         S_LEN_H: begin
            if (w_rx_ferr) begin
               w_state_nxt = S_ERR;
            end else if (w_rx_valid) begin
               w_len_h_nxt = w_rx_data;
               w_state_nxt = S_LEN_L;
            end
         end
         S_LEN_L: begin
            if (w_rx_ferr) begin
               w_state_nxt = S_ERR;
            end else if (w_rx_valid) begin
               w_len_nxt = w_len_rx;
               if ((w_len_rx != '0) && (w_len_rx <= C_MAX_N)) begin
                  w_state_nxt = S_DATA;
                  w_addr_nxt  = '0;
                  w_word_nxt  = '0;
                  w_byte_nxt  = '0;
`ifdef LOADER_CHECKSUM_EN
                  w_sum_nxt   = '0;
`endif
               end else begin
                  w_state_nxt = S_ERR;
               end
            end
         end
         S_DATA: begin
            if (w_rx_ferr) begin
               w_state_nxt = S_ERR;
            end else if (w_rx_valid) begin
               w_din_nxt  = {r_imem_din[23:0], w_rx_data};
               w_byte_nxt = r_byte_cnt + 1'b1;
`ifdef LOADER_CHECKSUM_EN
               w_sum_nxt  = r_sum + w_rx_data;
`endif
               if (r_byte_cnt == 2'd3) begin
                  w_we_nxt   = 1'b1;
                  w_word_nxt = r_word_cnt + 1'b1;
                  // Leaving DATA on the last word makes overrunning N impossible.
                  if (r_word_cnt == r_len - 1'b1) begin
`ifdef LOADER_CHECKSUM_EN
                     w_state_nxt = S_CSUM;
`else
                     w_state_nxt = S_DONE;
`endif
                  end
               end
            end
         end
`ifdef LOADER_CHECKSUM_EN
         S_CSUM: begin
            if (w_rx_ferr)
               w_state_nxt = S_ERR;
            else if (w_rx_valid)
               w_state_nxt = (w_rx_data == r_sum) ? S_DONE : S_ERR;
         end
`endif
         S_DONE: begin
            // Terminal until reset; all traffic is ignored.
         end
         S_ERR: begin
            if (w_rx_valid && (w_rx_data == SYNC_BYTE))
               w_state_nxt = S_LEN_H;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

endmodule
